// File: rtl/controle_varredura_servo.sv
// ----------------------------------------------------------------------------
// controle_varredura_servo
// Sweep sequencer placed ahead of the servo PWM generator. It steps the 3-bit
// width selector through positions 0..7 and back again (ping-pong). At each
// position it waits for the servo to settle, requests one distance
// measurement, and then advances. It advances when the measurement is
// acknowledged, or when the acknowledge does not arrive in time.
//
// Ports
//   clock_i          system clock, rising edge
//   reset_i          asynchronous, active-high; clears all state
//   ligar_i          sweep enable, sampled in INICIAL and PROXIMA only
//   pronto_medida_i  measurement acknowledge, sampled in MEDE only
//   posicao_o        [2:0] position selector for the PWM generator
//   medir_o          one-cycle measurement request
//   fim_varredura_o  one-cycle pulse on each direction reversal
//   timeout_o        one-cycle pulse when MEDE expires without acknowledge
//   db_estado_o      [2:0] current FSM state code (debug)
//
// state     | meaning
// INICIAL   | idle, position and direction held until ligar_i
// POSICIONA | servo settling, T_ASSENTA cycles
// MEDE      | measurement requested, waiting for acknowledge or timeout
// PROXIMA   | one cycle, steps posicao and picks the sweep direction
// ----------------------------------------------------------------------------
module controle_varredura_servo #(
    parameter int unsigned T_ASSENTA = 25000000,
    parameter int unsigned T_TIMEOUT = 5000000
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       ligar_i,
    input  logic       pronto_medida_i,
    output logic [2:0] posicao_o,
    output logic       medir_o,
    output logic       fim_varredura_o,
    output logic       timeout_o,
    output logic [2:0] db_estado_o
);

    typedef enum logic [1:0] {
        INICIAL   = 2'd0,
        POSICIONA = 2'd1,
        MEDE      = 2'd2,
        PROXIMA   = 2'd3
    } estado_t;

    localparam logic [31:0] ASSENTA_FIM = 32'(T_ASSENTA - 1);
    localparam logic [31:0] TIMEOUT_FIM = 32'(T_TIMEOUT - 1);

    estado_t     estado_q;
    logic [31:0] timer_q;
    logic [2:0]  posicao_q;
    logic        subindo_q;
    logic        medir_q;
    logic        fim_q;
    logic        timeout_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            estado_q  <= INICIAL;
            timer_q   <= '0;
            posicao_q <= 3'd0;
            subindo_q <= 1'b1;
            medir_q   <= 1'b0;
            fim_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // The pulse outputs are high for one cycle only, unless a branch
            // below sets them again.
            medir_q   <= 1'b0;
            fim_q     <= 1'b0;
            timeout_q <= 1'b0;
            case (estado_q)
                INICIAL: begin
                    if (ligar_i) begin
                        estado_q <= POSICIONA;
                        timer_q  <= '0;
                    end
                end
                POSICIONA: begin
                    if (timer_q == ASSENTA_FIM) begin
                        estado_q <= MEDE;
                        timer_q  <= '0;
                        medir_q  <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 32'd1;
                    end
                end
                MEDE: begin
                    // The acknowledge is checked before expiry, so an
                    // acknowledge on the last cycle suppresses the timeout.
                    if (pronto_medida_i) begin
                        estado_q <= PROXIMA;
                        timer_q  <= '0;
                    end else if (timer_q == TIMEOUT_FIM) begin
                        estado_q  <= PROXIMA;
                        timer_q   <= '0;
                        timeout_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 32'd1;
                    end
                end
                PROXIMA: begin
                    if (subindo_q && posicao_q == 3'd7) begin
                        subindo_q <= 1'b0;
                        posicao_q <= 3'd6;
                        fim_q     <= 1'b1;
                    end else if (!subindo_q && posicao_q == 3'd0) begin
                        subindo_q <= 1'b1;
                        posicao_q <= 3'd1;
                        fim_q     <= 1'b1;
                    end else if (subindo_q) begin
                        posicao_q <= posicao_q + 3'd1;
                    end else begin
                        posicao_q <= posicao_q - 3'd1;
                    end
                    timer_q  <= '0;
                    estado_q <= ligar_i ? POSICIONA : INICIAL;
                end
                default: begin
                    estado_q <= INICIAL;
                    timer_q  <= '0;
                end
            endcase
        end
    end

    assign posicao_o       = posicao_q;
    assign medir_o         = medir_q;
    assign fim_varredura_o = fim_q;
    assign timeout_o       = timeout_q;
    assign db_estado_o     = {1'b0, estado_q};

endmodule

// File: tb/tb_controle_varredura_servo.sv
module tb_controle_varredura_servo;

    logic       clock = 1'b0;
    logic       reset;
    logic       ligar;
    logic       pronto;
    logic [2:0] posicao;
    logic       medir;
    logic       fim;
    logic       tmo;
    logic [2:0] db;

    int vectors     = 0;
    int miscompares = 0;
    int n;
    int cnt;

    logic [2:0] pos_seq [15];
    logic       fim_seq [15];

    always #5 clock = ~clock;

    controle_varredura_servo #(
        .T_ASSENTA(10),
        .T_TIMEOUT(20)
    ) dut (
        .clock_i        (clock),
        .reset_i        (reset),
        .ligar_i        (ligar),
        .pronto_medida_i(pronto),
        .posicao_o      (posicao),
        .medir_o        (medir),
        .fim_varredura_o(fim),
        .timeout_o      (tmo),
        .db_estado_o    (db)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_medir(input int budget, output int waited);
        waited = 0;
        while (medir !== 1'b1 && waited < budget) begin
            tick();
            waited++;
        end
        chk("medir_seen", 32'(medir), 32'd1);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        ligar  = 1'b0;
        pronto = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Acknowledge in the request cycle, then check the stepped position.
    task automatic fast_step(input logic [2:0] exp_pos, input logic exp_fim);
        int w;
        wait_medir(40, w);
        pronto = 1'b1;
        tick();
        pronto = 1'b0;
        tick();
        chk("fast_pos", 32'(posicao), 32'(exp_pos));
        chk("fast_fim", 32'(fim), 32'(exp_fim));
    endtask

    initial begin
        pos_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6,
                    3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
        fim_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset values
        reset  = 1'b1;
        ligar  = 1'b0;
        pronto = 1'b0;
        tick();
        chk("rst_posicao", 32'(posicao), 32'd0);
        chk("rst_medir", 32'(medir), 32'd0);
        chk("rst_fim", 32'(fim), 32'd0);
        chk("rst_timeout", 32'(tmo), 32'd0);
        chk("rst_estado", 32'(db), 32'd0);
        reset = 1'b0;
        tick();
        tick();
        chk("idle_estado", 32'(db), 32'd0);
        chk("idle_posicao", 32'(posicao), 32'd0);

        // Async reset while medir is high in MEDE at posicao 5
        ligar = 1'b1;
        fast_step(3'd1, 1'b0);
        fast_step(3'd2, 1'b0);
        fast_step(3'd3, 1'b0);
        fast_step(3'd4, 1'b0);
        fast_step(3'd5, 1'b0);
        wait_medir(40, n);
        chk("pre_rst_posicao", 32'(posicao), 32'd5);
        chk("pre_rst_estado", 32'(db), 32'd2);
        reset = 1'b1;
        #1;
        chk("async_posicao", 32'(posicao), 32'd0);
        chk("async_medir", 32'(medir), 32'd0);
        chk("async_estado", 32'(db), 32'd0);
        ligar = 1'b0;
        tick();
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (medir === 1'b1) cnt++;
        end
        chk("no_medir_after_rst", cnt, 0);
        // Direction back to up: 0->1 and 1->2 without a reversal pulse
        ligar = 1'b1;
        fast_step(3'd1, 1'b0);
        fast_step(3'd2, 1'b0);

        // Full sweep with acknowledge 3 cycles after each request
        do_reset();
        ligar = 1'b1;
        for (int i = 0; i < 15; i++) begin
            wait_medir(40, n);
            if (i == 0) chk("first_medir_delay", n, 11);
            else        chk("medir_period", 5 + n, 15);
            chk("sweep_mede_estado", 32'(db), 32'd2);
            tick();
            chk("medir_one_cycle", 32'(medir), 32'd0);
            tick();
            tick();
            pronto = 1'b1;
            tick();
            pronto = 1'b0;
            chk("sweep_proxima", 32'(db), 32'd3);
            chk("sweep_no_timeout", 32'(tmo), 32'd0);
            tick();
            chk("sweep_posicao", 32'(posicao), 32'(pos_seq[i]));
            chk("sweep_fim", 32'(fim), 32'(fim_seq[i]));
        end

        // Timeout with no acknowledge
        do_reset();
        ligar = 1'b1;
        wait_medir(40, n);
        cnt = 0;
        while (tmo !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("timeout_seen", 32'(tmo), 32'd1);
        chk("timeout_delay", cnt, 20);
        chk("timeout_posicao_hold", 32'(posicao), 32'd0);
        chk("timeout_estado", 32'(db), 32'd3);
        tick();
        chk("timeout_pulse_width", 32'(tmo), 32'd0);
        chk("timeout_posicao_next", 32'(posicao), 32'd1);
        chk("timeout_to_posiciona", 32'(db), 32'd1);
        wait_medir(40, n);
        chk("timeout_next_medir", 1 + n, 11);

        // Acknowledge on the last MEDE cycle beats the timeout
        repeat (19) tick();
        pronto = 1'b1;
        tick();
        pronto = 1'b0;
        chk("same_cycle_no_timeout", 32'(tmo), 32'd0);
        chk("same_cycle_estado", 32'(db), 32'd3);
        tick();
        chk("same_cycle_timeout_after", 32'(tmo), 32'd0);
        chk("same_cycle_posicao", 32'(posicao), 32'd2);

        // Stray acknowledge in POSICIONA does not shorten settling
        pronto = 1'b1;
        repeat (5) tick();
        pronto = 1'b0;
        wait_medir(40, n);
        chk("stray_ack_medir_delay", 5 + n, 10);
        // Acknowledge in the request cycle itself
        pronto = 1'b1;
        tick();
        pronto = 1'b0;
        chk("ack_in_medir_cycle", 32'(db), 32'd3);
        tick();
        chk("ack_in_medir_posicao", 32'(posicao), 32'd3);

        // Pause at posicao 6 going down, then resume
        fast_step(3'd4, 1'b0);
        fast_step(3'd5, 1'b0);
        fast_step(3'd6, 1'b0);
        fast_step(3'd7, 1'b0);
        fast_step(3'd6, 1'b1);
        wait_medir(40, n);
        chk("pause_mede_posicao", 32'(posicao), 32'd6);
        ligar  = 1'b0;
        pronto = 1'b1;
        tick();
        pronto = 1'b0;
        tick();
        chk("pause_posicao", 32'(posicao), 32'd5);
        chk("pause_estado", 32'(db), 32'd0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (medir === 1'b1) cnt++;
        end
        chk("pause_no_medir", cnt, 0);
        chk("pause_hold_posicao", 32'(posicao), 32'd5);
        chk("pause_hold_estado", 32'(db), 32'd0);
        ligar = 1'b1;
        wait_medir(40, n);
        chk("resume_medir_delay", n, 11);
        chk("resume_posicao", 32'(posicao), 32'd5);
        pronto = 1'b1;
        tick();
        pronto = 1'b0;
        tick();
        chk("resume_step_down", 32'(posicao), 32'd4);
        chk("resume_no_fim", 32'(fim), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
